// File: rtl/decoder38_pkg.sv
// Shared widths, types and the one-hot helper for the 3-to-8 decoder.
package decoder38_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] dec_t;

    function automatic logic onehot_ok(input dec_t v);
        return (v != '0) && ((v & (v - dec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder slice with enable; unknown selects decode to zero.
module decoder_2to4 (
    input  logic [1:0] a,
    input  logic       en,
    output logic [3:0] d
);

    always_comb begin
        d = 4'b0000;
        if (en) begin
            unique case (a)
                2'b00:   d = 4'b0001;
                2'b01:   d = 4'b0010;
                2'b10:   d = 4'b0100;
                2'b11:   d = 4'b1000;
                default: d = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with optional output register stage.
// Define DECODER_ONEHOT_CHECK_EN to add the sticky one-hot checker (err port).
module decoder_3to8
    import decoder38_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic [7:0] D,
`ifdef DECODER_ONEHOT_CHECK_EN
    output logic       err,
`endif
    output logic       valid
);

    sel_t sel;
    dec_t dec_d;

    assign sel = {z, y, x};

    // z picks which half is enabled; both halves share {y,x}
    decoder_2to4 u_lo (
        .a  (sel[1:0]),
        .en (en & ~z),
        .d  (dec_d[3:0])
    );

    decoder_2to4 u_hi (
        .a  (sel[1:0]),
        .en (en & z),
        .d  (dec_d[7:4])
    );

    generate
        if (REG_OUT) begin : g_reg
            dec_t d_q;
            logic valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    d_q     <= dec_d;
                    valid_q <= en;
                end
            end

            assign D     = d_q;
            assign valid = valid_q;
        end else begin : g_comb
            assign D     = dec_d;
            assign valid = en;
        end
    endgenerate

`ifdef DECODER_ONEHOT_CHECK_EN
    logic err_q;
    logic bad;

    assign bad = ((D != '0) && !onehot_ok(D)) || (valid && (D == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed plus random checks of registered and combinational decoder builds.
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic [7:0] d_r;
    logic [7:0] d_c;
    logic       v_r;
    logic       v_c;
`ifdef DECODER_ONEHOT_CHECK_EN
    logic       err_r;
    logic       err_c;
`endif

    int passed = 0;
    int total  = 0;

    decoder_3to8 #(.REG_OUT(1'b1)) u_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x     (sel[0]),
        .y     (sel[1]),
        .z     (sel[2]),
        .D     (d_r),
`ifdef DECODER_ONEHOT_CHECK_EN
        .err   (err_r),
`endif
        .valid (v_r)
    );

    decoder_3to8 #(.REG_OUT(1'b0)) u_comb (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x     (sel[0]),
        .y     (sel[1]),
        .z     (sel[2]),
        .D     (d_c),
`ifdef DECODER_ONEHOT_CHECK_EN
        .err   (err_c),
`endif
        .valid (v_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: enabled decode is the power of two of the select index
    function automatic logic [7:0] model(input logic e, input int s);
        int p;
        p = 2 ** s;
        return e ? p[7:0] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        logic       exp_v;

        rst = 1'b1;
        en  = 1'b1;
        sel = 3'b101;
        #3;
        check("rst_d", d_r, 8'h00);
        check("rst_valid", {7'b0, v_r}, 8'h00);
        check("comb_at_rst", d_c, 8'h20);
        rst = 1'b0;
        tick();
        check("post_rst_d", d_r, 8'h20);
        check("post_rst_valid", {7'b0, v_r}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
            check("sweep_d", d_r, model(1'b1, i));
            check("sweep_valid", {7'b0, v_r}, 8'h01);
        end

        sel = 3'b011;
        en  = 1'b1;
        tick();
        check("dis_on", d_r, 8'h08);
        en = 1'b0;
        tick();
        check("dis_off", d_r, 8'h00);
        check("dis_valid", {7'b0, v_r}, 8'h00);

        sel = 3'b110;
        en  = 1'b1;
        tick();
        check("mid_pre", d_r, 8'h40);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async", d_r, 8'h00);
        check("mid_async_v", {7'b0, v_r}, 8'h00);
        tick();
        check("mid_hold", d_r, 8'h00);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check("mid_released_off", d_r, 8'h00);
        en = 1'b1;
        tick();
        check("mid_first_en", d_r, 8'h40);

        sel = 3'b100;
        en  = 1'b1;
        #1;
        check("comb_on", d_c, 8'h10);
        check("comb_valid", {7'b0, v_c}, 8'h01);
        en = 1'b0;
        #1;
        check("comb_off", d_c, 8'h00);
        check("comb_valid_off", {7'b0, v_c}, 8'h00);

        for (int n = 0; n < 200; n++) begin
            tick();
            en  = 1'($urandom_range(0, 3) != 0);
            sel = 3'($urandom_range(0, 7));
            exp_d = model(en, int'(sel));
            exp_v = en;
            #1;
            check("rnd_comb", d_c, exp_d);
            tick();
            check("rnd_reg", d_r, exp_d);
            check("rnd_valid", {7'b0, v_r}, {7'b0, exp_v});
            check("rnd_onehot", 8'($countones(d_r) <= 1), 8'h01);
        end

`ifdef DECODER_ONEHOT_CHECK_EN
        tick();
        check("err_reg", {7'b0, err_r}, 8'h00);
        check("err_comb", {7'b0, err_c}, 8'h00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
